// File: rtl/gate_check_pkg.sv
// Shared definitions for the two-input gate response checker: gate bit indices,
// FSM states, beat payload and the golden gate function.
package gate_check_pkg;

  localparam int unsigned NUM_GATES = 7;

  localparam int unsigned GATE_AND  = 0;
  localparam int unsigned GATE_OR   = 1;
  localparam int unsigned GATE_NOT  = 2;
  localparam int unsigned GATE_NOR  = 3;
  localparam int unsigned GATE_NAND = 4;
  localparam int unsigned GATE_XOR  = 5;
  localparam int unsigned GATE_XNOR = 6;

  typedef logic [NUM_GATES-1:0] gate_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic      a;
    logic      b;
    gate_vec_t y;
  } beat_t;

  // Expected outputs of every gate for one {a,b} pair; the inverter only looks at a.
  function automatic gate_vec_t golden_gates(input logic a, input logic b);
    gate_vec_t g;
    g            = '0;
    g[GATE_AND]  = a & b;
    g[GATE_OR]   = a | b;
    g[GATE_NOT]  = ~a;
    g[GATE_NOR]  = ~(a | b);
    g[GATE_NAND] = ~(a & b);
    g[GATE_XOR]  = a ^ b;
    g[GATE_XNOR] = ~(a ^ b);
    return g;
  endfunction

endpackage

// File: rtl/gate_response_checker_if.sv
// Beat handshake between a gate stimulus source (master) and the checker (slave).
interface gate_response_checker_if;
  import gate_check_pkg::*;

  logic      in_valid;
  logic      in_ready;
  logic      in_a;
  logic      in_b;
  gate_vec_t in_y;

  modport master (output in_valid, output in_a, output in_b, output in_y, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, input in_y, output in_ready);

endinterface

// File: rtl/gate_golden_model.sv
// Purely combinational reference for the gate family: {a,b} -> expected 7-bit vector.
module gate_golden_model
  import gate_check_pkg::*;
(
  input  logic      a,
  input  logic      b,
  output gate_vec_t y_c
);

  assign y_c = golden_gates(a, b);

endmodule

// File: rtl/gate_response_checker.sv
// Self-checking sink for the gate family: two-stage compare pipeline, counters and session FSM.
// Optional GATE_CHECK_COVERAGE_EN adds {a,b} coverage bins and makes pass require full coverage.
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 100,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  gate_response_checker_if.slave beat,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     vec_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [1:0]           first_err_ab,
  output gate_vec_t            first_err_mask,
  output gate_vec_t            gate_err_mask
`ifdef GATE_CHECK_COVERAGE_EN
  ,
  output logic [3:0]           cov_bins,
  output logic                 cov_full
`endif
);

  localparam logic [CNT_W-1:0] NUM_C  = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NUM_VECTORS - 1);

  state_t           state, state_next;
  logic             xfer_c;
  logic             clear_c;
  logic [CNT_W-1:0] vec_next;
  logic             ready_next;
  logic             busy_next;
  logic             done_next;
  logic             pass_next;

  logic             s1_valid;
  beat_t            s1;
  gate_vec_t        expected_c;
  gate_vec_t        mask_c;

`ifdef GATE_CHECK_COVERAGE_EN
  logic [3:0]       cov_next_c;
  assign cov_next_c = cov_bins | (4'b0001 << {beat.in_a, beat.in_b});
`endif

  // in_ready is a register, so a transfer never depends combinationally on in_valid.
  assign xfer_c = beat.in_valid && beat.in_ready;

  gate_golden_model u_golden (
    .a   (s1.a),
    .b   (s1.b),
    .y_c (expected_c)
  );

  assign mask_c = s1.y ^ expected_c;

  // Session state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state plus next values of the registered status outputs.
  always_comb begin
    state_next = state;
    clear_c    = 1'b0;
    unique case (state)
      IDLE:  if (start) begin
               state_next = RUN;
               clear_c    = 1'b1;
             end
      RUN:   if (xfer_c && (vec_count == LAST_C)) state_next = DRAIN;
      DRAIN: if (!s1_valid) state_next = DONE;
      DONE:  if (start) begin
               state_next = RUN;
               clear_c    = 1'b1;
             end
      default: state_next = IDLE;
    endcase

    vec_next = vec_count;
    if (clear_c)     vec_next = '0;
    else if (xfer_c) vec_next = vec_count + CNT_W'(1);

    ready_next = (state_next == RUN) && (vec_next < NUM_C);
    busy_next  = (state_next == RUN) || (state_next == DRAIN);
    done_next  = (state_next == DONE);
    // err_count is final by the time DRAIN sees an empty pipeline.
`ifdef GATE_CHECK_COVERAGE_EN
    pass_next  = done_next && (err_count == '0) && cov_full;
`else
    pass_next  = done_next && (err_count == '0);
`endif
  end

  // Status outputs, stage-1 capture and stage-2 scoring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat.in_ready  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      vec_count      <= '0;
      s1_valid       <= 1'b0;
      s1             <= '0;
      err_count      <= '0;
      first_err_ab   <= '0;
      first_err_mask <= '0;
      gate_err_mask  <= '0;
`ifdef GATE_CHECK_COVERAGE_EN
      cov_bins       <= '0;
      cov_full       <= 1'b0;
`endif
    end else begin
      beat.in_ready <= ready_next;
      busy          <= busy_next;
      done          <= done_next;
      pass          <= pass_next;
      vec_count     <= vec_next;

      s1_valid <= xfer_c;
      if (xfer_c) s1 <= '{a: beat.in_a, b: beat.in_b, y: beat.in_y};

      if (clear_c) begin
        err_count      <= '0;
        first_err_ab   <= '0;
        first_err_mask <= '0;
        gate_err_mask  <= '0;
      end else if (s1_valid && (mask_c != '0)) begin
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
        gate_err_mask <= gate_err_mask | mask_c;
        // A zero error count means this is the first failing beat of the session.
        if (err_count == '0) begin
          first_err_ab   <= {s1.a, s1.b};
          first_err_mask <= mask_c;
        end
      end

`ifdef GATE_CHECK_COVERAGE_EN
      if (clear_c) begin
        cov_bins <= '0;
        cov_full <= 1'b0;
      end else if (xfer_c) begin
        cov_bins <= cov_next_c;
        cov_full <= &cov_next_c;
      end
`endif
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench for gate_response_checker: a 4-beat and a 100-beat instance,
// session expectations queued at start, checked by a monitor when done rises.
module tb_gate_response_checker;
  import gate_check_pkg::*;

  localparam int unsigned CW = 16;
`ifdef GATE_CHECK_COVERAGE_EN
  localparam bit COV_EN = 1'b1;
`else
  localparam bit COV_EN = 1'b0;
`endif

  // Hand-derived correct response vectors, bits 6..0 = xnor,xor,nand,nor,not,or,and.
  localparam logic [6:0] Y00 = 7'b1011100;
  localparam logic [6:0] Y01 = 7'b0110110;
  localparam logic [6:0] Y10 = 7'b0110010;
  localparam logic [6:0] Y11 = 7'b1000011;

  typedef struct {
    logic [CW-1:0] vec;
    logic [CW-1:0] err;
    logic [1:0]    ab;
    logic [6:0]    fmask;
    logic [6:0]    gmask;
    logic          pass;
    logic [3:0]    cov;
    logic          covf;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start4, start100;
  always #5 clk = ~clk;

  logic          busy4, done4, pass4, busy100, done100, pass100;
  logic [CW-1:0] vec4, err4, vec100, err100;
  logic [1:0]    fab4, fab100;
  logic [6:0]    fm4, gm4, fm100, gm100;
`ifdef GATE_CHECK_COVERAGE_EN
  logic [3:0]    cov4, cov100;
  logic          covf4, covf100;
`endif

  gate_response_checker_if bif4 ();
  gate_response_checker_if bif100 ();

  gate_response_checker #(.NUM_VECTORS(4), .CNT_W(CW)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .beat(bif4),
    .busy(busy4), .done(done4), .pass(pass4), .vec_count(vec4), .err_count(err4),
    .first_err_ab(fab4), .first_err_mask(fm4), .gate_err_mask(gm4)
`ifdef GATE_CHECK_COVERAGE_EN
    , .cov_bins(cov4), .cov_full(covf4)
`endif
  );

  gate_response_checker #(.NUM_VECTORS(100), .CNT_W(CW)) u_dut100 (
    .clk(clk), .rst(rst), .start(start100), .beat(bif100),
    .busy(busy100), .done(done100), .pass(pass100), .vec_count(vec100), .err_count(err100),
    .first_err_ab(fab100), .first_err_mask(fm100), .gate_err_mask(gm100)
`ifdef GATE_CHECK_COVERAGE_EN
    , .cov_bins(cov100), .cov_full(covf100)
`endif
  );

  int   errors = 0;
  int   checks = 0;
  exp_t q4[$];
  exp_t q100[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int v, input int e, input logic [1:0] ab,
                              input logic [6:0] fm, input logic [6:0] gm,
                              input logic p, input logic [3:0] cv);
    exp_t x;
    x.vec = CW'(v); x.err = CW'(e); x.ab = ab; x.fmask = fm; x.gmask = gm;
    x.pass = p; x.cov = cv; x.covf = &cv;
    return x;
  endfunction

  function automatic exp_t snap(input bit big);
    exp_t x;
    x.vec   = big ? vec100 : vec4;
    x.err   = big ? err100 : err4;
    x.ab    = big ? fab100 : fab4;
    x.fmask = big ? fm100  : fm4;
    x.gmask = big ? gm100  : gm4;
    x.pass  = big ? pass100 : pass4;
`ifdef GATE_CHECK_COVERAGE_EN
    x.cov   = big ? cov100 : cov4;
    x.covf  = big ? covf100 : covf4;
`else
    x.cov   = 4'b0;
    x.covf  = 1'b0;
`endif
    return x;
  endfunction

  task automatic compare(input string tag, input exp_t e, input exp_t a);
    chk({tag, ".vec_count"},      32'(a.vec),   32'(e.vec));
    chk({tag, ".err_count"},      32'(a.err),   32'(e.err));
    chk({tag, ".first_err_ab"},   32'(a.ab),    32'(e.ab));
    chk({tag, ".first_err_mask"}, 32'(a.fmask), 32'(e.fmask));
    chk({tag, ".gate_err_mask"},  32'(a.gmask), 32'(e.gmask));
    chk({tag, ".pass"},           32'(a.pass),  32'(e.pass));
    if (COV_EN) begin
      chk({tag, ".cov_bins"}, 32'(a.cov),  32'(e.cov));
      chk({tag, ".cov_full"}, 32'(a.covf), 32'(e.covf));
    end
  endtask

  task automatic chk_zero(input string tag, input bit big);
    compare(tag, mk(0, 0, 2'b00, 7'b0, 7'b0, 1'b0, 4'b0), snap(big));
    chk({tag, ".busy"},     32'(big ? busy100 : busy4), 32'd0);
    chk({tag, ".done"},     32'(big ? done100 : done4), 32'd0);
    chk({tag, ".in_ready"}, 32'(big ? bif100.in_ready : bif4.in_ready), 32'd0);
  endtask

  // Monitor: on each rising done, pop the queued session expectation and compare.
  int   ncyc = 0;
  int   last_xfer100 = 0;
  logic prev4 = 1'b0, prev100 = 1'b0;
  always @(negedge clk) begin
    ncyc++;
    if (bif100.in_valid && bif100.in_ready) last_xfer100 = ncyc;
    if (done4 && !prev4) begin
      if (q4.size() == 0) begin
        checks++; errors++; $display("FAIL sb4: done with no queued session");
      end else compare("sb4", q4.pop_front(), snap(1'b0));
      chk("sb4.busy_at_done", 32'(busy4), 32'd0);
      chk("sb4.ready_at_done", 32'(bif4.in_ready), 32'd0);
    end
    if (done100 && !prev100) begin
      if (q100.size() == 0) begin
        checks++; errors++; $display("FAIL sb100: done with no queued session");
      end else compare("sb100", q100.pop_front(), snap(1'b1));
      checks++;
      if (ncyc - last_xfer100 < 3) begin
        errors++;
        $display("FAIL done_latency: %0d cycles after last transfer, need >= 3", ncyc - last_xfer100);
      end
    end
    prev4   = done4;
    prev100 = done100;
  end

  // All driving tasks are entered and left 1 time unit after a rising edge.
  task automatic beat4(input logic [1:0] ab, input logic [6:0] y);
    int n = 0;
    bif4.in_valid = 1'b1; bif4.in_a = ab[1]; bif4.in_b = ab[0]; bif4.in_y = y;
    while (!bif4.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!bif4.in_ready) begin
      checks++; errors++; $display("FAIL beat4_timeout: in_ready stayed 0");
    end else begin
      @(posedge clk); #1;
    end
    bif4.in_valid = 1'b0;
  endtask

  task automatic beat100(input logic [1:0] ab, input logic [6:0] y, input int gap);
    int n = 0;
    bif100.in_valid = 1'b0;
    repeat (gap) begin
      bif100.in_a = 1'($urandom); bif100.in_b = 1'($urandom); bif100.in_y = 7'($urandom);
      @(posedge clk); #1;
    end
    bif100.in_valid = 1'b1; bif100.in_a = ab[1]; bif100.in_b = ab[0]; bif100.in_y = y;
    while (!bif100.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!bif100.in_ready) begin
      checks++; errors++; $display("FAIL beat100_timeout: in_ready stayed 0");
    end else begin
      @(posedge clk); #1;
    end
    bif100.in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit big);
    int n = 0;
    while (!(big ? done100 : done4) && n < 40) begin @(posedge clk); #1; n++; end
    if (!(big ? done100 : done4)) begin
      checks++; errors++; $display("FAIL wait_done: done never rose (big=%0d)", big);
    end
    @(negedge clk); @(posedge clk); #1;
  endtask

  task automatic pulse_start(input bit big);
    if (big) start100 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; start100 = 1'b0;
  endtask

  function automatic logic [6:0] yok(input logic [1:0] ab);
    case (ab)
      2'b00:   return Y00;
      2'b01:   return Y01;
      2'b10:   return Y10;
      default: return Y11;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start4 = 1'b0; start100 = 1'b0;
    bif4.in_valid = 1'b0; bif4.in_a = 1'b0; bif4.in_b = 1'b0; bif4.in_y = '0;
    bif100.in_valid = 1'b0; bif100.in_a = 1'b0; bif100.in_b = 1'b0; bif100.in_y = '0;
    @(posedge clk); @(posedge clk); #1;
    chk_zero("reset4", 1'b0);
    chk_zero("reset100", 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    // S1: all four combinations, correct responses, valid held high.
    q4.push_back(mk(4, 0, 2'b00, 7'b0, 7'b0, 1'b1, 4'b1111));
    pulse_start(1'b0);
    chk("s1.in_ready_after_start", 32'(bif4.in_ready), 32'd1);
    beat4(2'b00, Y00); beat4(2'b01, Y01); beat4(2'b10, Y10); beat4(2'b11, Y11);
    chk("s1.in_ready_after_last", 32'(bif4.in_ready), 32'd0);
    chk("s1.busy_in_drain", 32'(busy4), 32'd1);
    wait_done(1'b0);

    // S2: start in DONE alongside a valid beat; the beat must not be taken. Then xor fault on {1,0}.
    q4.push_back(mk(1 + 3, 1, 2'b10, 7'b0100000, 7'b0100000, 1'b0, 4'b1111));
    bif4.in_valid = 1'b1; bif4.in_a = 1'b1; bif4.in_b = 1'b1; bif4.in_y = 7'b0;
    pulse_start(1'b0);
    bif4.in_valid = 1'b0;
    chk("s2.no_beat_on_start", 32'(vec4), 32'd0);
    chk("s2.busy", 32'(busy4), 32'd1);
    chk("s2.done_cleared", 32'(done4), 32'd0);
    chk("s2.in_ready", 32'(bif4.in_ready), 32'd1);
    beat4(2'b00, Y00); beat4(2'b01, Y01); beat4(2'b10, 7'b0010010); beat4(2'b11, Y11);
    wait_done(1'b0);

    // S3: and fault on {0,0}, then nor fault on {1,0}; first mask keeps bit0 only.
    q4.push_back(mk(4, 2, 2'b00, 7'b0000001, 7'b0001001, 1'b0, 4'b1111));
    pulse_start(1'b0);
    beat4(2'b00, 7'b1011101); beat4(2'b01, Y01); beat4(2'b10, 7'b0111010); beat4(2'b11, Y11);
    wait_done(1'b0);

    // S4: four correct {1,1} beats; passes only when coverage is not required.
    q4.push_back(mk(4, 0, 2'b00, 7'b0, 7'b0, !COV_EN, 4'b1000));
    pulse_start(1'b0);
    repeat (4) beat4(2'b11, Y11);
    wait_done(1'b0);

    // A: 100 correct beats with random valid gaps and junk data between beats.
    q100.push_back(mk(100, 0, 2'b00, 7'b0, 7'b0, 1'b1, 4'b1111));
    pulse_start(1'b1);
    for (int i = 0; i < 100; i++) beat100(2'(i), yok(2'(i)), int'($urandom_range(0, 2)));
    wait_done(1'b1);

    // B: abort with reset after 50 beats; everything must clear immediately.
    pulse_start(1'b1);
    for (int i = 0; i < 50; i++) beat100(2'(i), yok(2'(i)), 0);
    chk("b.vec_before_abort", 32'(vec100), 32'd50);
    rst = 1'b1;
    #1;
    chk_zero("abort100", 1'b1);
    chk_zero("abort4", 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // C: clean session after the abort; single xnor fault on beat 7 ({1,1}).
    q100.push_back(mk(100, 1, 2'b11, 7'b1000000, 7'b1000000, 1'b0, 4'b1111));
    pulse_start(1'b1);
    chk("c.vec_from_zero", 32'(vec100), 32'd0);
    for (int i = 0; i < 100; i++)
      beat100(2'(i), (i == 7) ? 7'b0000011 : yok(2'(i)), int'($urandom_range(0, 1)));
    wait_done(1'b1);

    chk("sb4.all_sessions_done", 32'(q4.size()), 32'd0);
    chk("sb100.all_sessions_done", 32'(q100.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
